// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI slave front end of the single-port RAM:
//   FSM state encodings, the 2-bit command codes carried in the top two bits
//   of each received word, and default data widths.
//   No ports (package).
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int TX_WIDTH_DEF = 8;
    localparam int RX_WIDTH_DEF = TX_WIDTH_DEF + 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

    // Decoded by the RAM, passed through untouched by the SPI slave.
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_t;

endpackage

// File: rtl/spi_shift_out.sv
// ---------------------------------------------------------------------------
// spi_shift_out
//   Parallel-load, MSB-first output shifter for the MISO read-back path.
//   Once loaded it presents TX_WIDTH bits, one per clock, then raises o_done
//   and stays quiet until cleared.
// Ports
//   clk      in   system clock, rising edge
//   i_rst    in   synchronous active-high reset
//   i_clear  in   frame end: drop any shift in progress and the done flag
//   i_load   in   load i_data into the shifter
//   i_data   in   TX_WIDTH parallel data
//   o_bit    out  current serial bit (0 when not shifting)
//   o_busy   out  bits remain to be shifted
//   o_done   out  a full word has been shifted out since the last clear
// ---------------------------------------------------------------------------
module spi_shift_out
    import spi_pkg::*;
#(
    parameter int TX_WIDTH = TX_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_load,
    input  logic [TX_WIDTH-1:0] i_data,
    output logic                o_bit,
    output logic                o_busy,
    output logic                o_done
);

    localparam int CNT_W = $clog2(TX_WIDTH + 1);

    logic [TX_WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0]    r_cnt;     // bits still to present, including the current one
    logic                r_done;

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_load) begin
            r_sreg <= i_data;
            r_cnt  <= CNT_W'(TX_WIDTH);
        end else if (r_cnt != '0) begin
            r_sreg <= {r_sreg[TX_WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_bit  = o_busy & r_sreg[TX_WIDTH-1];
    assign o_done = r_done;

endmodule

// File: rtl/spi_slave_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if
//   SPI slave (mode 0, MSB first, sampled on clk) in front of the single-port
//   RAM. Collects RX_WIDTH-bit {cmd, payload} words from MOSI and strobes them
//   out on rx_data/rx_valid. On a read-data frame, loads the RAM's tx_data
//   and shifts it back out on MISO.
// Ports
//   clk       in   system clock and SPI bit clock, rising edge
//   rst       in   synchronous active-high reset
//   SS_n      in   active-low slave select, frames a transaction
//   MOSI      in   serial data in
//   MISO      out  serial data out (0 when not shifting read data)
//   rx_data   out  last completed word {cmd[1:0], payload}
//   rx_valid  out  one-cycle strobe, rx_data just updated
//   tx_data   in   read data from RAM
//   tx_valid  in   tx_data valid (level)
// ---------------------------------------------------------------------------
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int TX_WIDTH = TX_WIDTH_DEF,
    parameter int RX_WIDTH = TX_WIDTH + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid
);

    localparam int                CNT_W     = $clog2(RX_WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(RX_WIDTH - 1);
    localparam logic [CNT_W-1:0]  WORD_DONE = CNT_W'(RX_WIDTH);

    spi_state_t           r_state;
    spi_state_t           w_next_state;
    logic [CNT_W-1:0]     r_bit_cnt;       // bits of the current word sampled so far
    logic [RX_WIDTH-2:0]  r_shift;
    logic [RX_WIDTH-1:0]  r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rd_addr_done;  // survives SS_n; cleared by rst or a read-data word

    logic                 w_sample;
    logic                 w_complete;
    logic                 w_load;
    logic                 w_tx_bit;
    logic                 w_tx_busy;
    logic                 w_tx_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_complete   = 1'b0;
        w_load       = 1'b0;
        if (SS_n) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next_state = CHK_CMD;
                end
                CHK_CMD: begin
                    w_sample = 1'b1;
                    if (!MOSI) begin
                        w_next_state = WRITE;
                    end else if (r_rd_addr_done) begin
                        w_next_state = READ_DATA;
                    end else begin
                        w_next_state = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (r_bit_cnt != WORD_DONE) begin
                        w_sample   = 1'b1;
                        w_complete = (r_bit_cnt == LAST_BIT);
                    end
                    // r_rx_valid high marks the strobe cycle, whose tx_valid may be stale.
                    if (r_state == READ_DATA && r_bit_cnt == WORD_DONE && !r_rx_valid &&
                        tx_valid && !w_tx_busy && !w_tx_done) begin
                        w_load = 1'b1;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_done <= 1'b0;
        end else begin
            r_rx_valid <= w_complete;
            if (SS_n) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_sample) begin
                r_shift   <= {r_shift[RX_WIDTH-3:0], MOSI};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_complete) begin
                r_rx_data <= {r_shift, MOSI};
                if (r_state == READ_ADD) begin
                    r_rd_addr_done <= 1'b1;
                end else if (r_state == READ_DATA) begin
                    r_rd_addr_done <= 1'b0;
                end
            end
        end
    end

    spi_shift_out #(
        .TX_WIDTH (TX_WIDTH)
    ) u_shift_out (
        .clk     (clk),
        .i_rst   (rst),
        .i_clear (SS_n),
        .i_load  (w_load),
        .i_data  (tx_data),
        .o_bit   (w_tx_bit),
        .o_busy  (w_tx_busy),
        .o_done  (w_tx_done)
    );

    assign MISO     = w_tx_bit;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_if
//   Self-checking bench for spi_slave_if. A frame-level reference model counts
//   clock edges since SS_n fell and derives rx_data/rx_valid/MISO from that
//   position; a compare process checks every cycle, and directed frames pin
//   literal values on top of the model.
// ---------------------------------------------------------------------------
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en  = 1'b0;
    bit rand_tx = 1'b0;

    always #5 clk = ~clk;

    spi_slave_if #(
        .TX_WIDTH (8),
        .RX_WIDTH (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // ---------------- reference model ----------------
    // k = number of SS_n-low edges in the current frame. Edge 1 leaves IDLE,
    // edges 2..11 sample word bits 9..0, the strobe cycle follows edge 11,
    // and a read-data load may happen on edge 13 or later.
    int         k = 0;
    logic [9:0] m_word = '0;
    bit         m_is_read = 1'b0;
    bit         m_is_rd_data = 1'b0;
    bit         m_rdd = 1'b0;
    bit         m_served = 1'b0;
    logic       m_rx_valid = 1'b0;
    logic [9:0] m_rx_data = '0;
    bit         mq[$];

    always @(posedge clk) begin
        if (rst) begin
            k = 0; m_word = '0; m_is_read = 0; m_is_rd_data = 0; m_rdd = 0;
            m_served = 0; m_rx_valid = 0; m_rx_data = '0; mq.delete();
        end else if (SS_n) begin
            k = 0; m_is_read = 0; m_is_rd_data = 0; m_served = 0;
            m_rx_valid = 0; mq.delete();
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_is_rd_data && k >= 12 && !m_served && tx_valid) begin
                for (int i = 7; i >= 0; i--) mq.push_back(tx_data[i]);
                m_served = 1;
            end
            k++;
            if (k >= 2 && k <= 11) m_word = {m_word[8:0], MOSI};
            if (k == 2) begin
                m_is_read    = MOSI;
                m_is_rd_data = MOSI && m_rdd;
            end
            m_rx_valid = (k == 11);
            if (k == 11) begin
                m_rx_data = m_word;
                if (m_is_read) m_rdd = !m_is_rd_data;
            end
        end
    end

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rx_valid", {9'b0, rx_valid}, {9'b0, m_rx_valid});
            check("cyc_rx_data", rx_data, m_rx_data);
            check("cyc_miso", {9'b0, MISO}, {9'b0, (mq.size() > 0) ? mq[0] : 1'b0});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_tx) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
        end
    endtask

    // Returns in the strobe cycle.
    task automatic send_word(input logic [9:0] w);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        cyc();
        for (int i = 9; i >= 0; i--) begin
            MOSI = w[i];
            cyc();
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        cyc();
    endtask

    task automatic capture8(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b = {b[6:0], MISO};
            cyc();
        end
    endtask

    task automatic miso_quiet(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            seen = seen | MISO;
            cyc();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       seen;
        logic [9:0] w;
        int         nb;
        int         extra;

        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_rx_valid", {9'b0, rx_valid}, 10'd0);
        check("rst_rx_data", rx_data, 10'h000);
        check("rst_miso", {9'b0, MISO}, 10'd0);

        // write address
        send_word(10'b00_1010_0101);
        check("wr_addr_valid", {9'b0, rx_valid}, 10'd1);
        check("wr_addr_data", rx_data, 10'h0A5);
        check("wr_addr_miso", {9'b0, MISO}, 10'd0);
        cyc();
        check("wr_addr_strobe_len", {9'b0, rx_valid}, 10'd0);
        end_frame();

        // write data, then trailing bits in the same frame are ignored
        send_word(10'b01_0011_1100);
        check("wr_data_data", rx_data, 10'h13C);
        for (int i = 0; i < 12; i++) begin
            MOSI = 1'($urandom);
            cyc();
        end
        check("wr_trailing_hold", rx_data, 10'h13C);
        end_frame();

        // read address, then read data in a new frame
        send_word(10'b10_1010_0101);
        check("rd_addr_data", rx_data, 10'h2A5);
        end_frame();
        send_word(10'h300);
        check("rd_data_data", rx_data, 10'h300);
        tx_valid = 1'b1; tx_data = 8'h3C;
        cyc();
        check("rd_data_no_early_load", {9'b0, MISO}, 10'd0);
        cyc();
        capture8(b);
        check("rd_data_miso_byte", {2'b0, b}, 10'h03C);
        check("rd_data_miso_after", {9'b0, MISO}, 10'd0);
        tx_valid = 1'b0;
        end_frame();

        // rd_addr_done was cleared: cmd 11 now acts as read-address, no MISO
        tx_valid = 1'b1; tx_data = 8'hFF;
        send_word(10'h3FF);
        miso_quiet(12, seen);
        check("rdd_cleared_no_miso", {9'b0, seen}, 10'd0);
        tx_valid = 1'b0;
        end_frame();

        // abort after 5 bits, then a normal frame
        SS_n = 1'b0; cyc();
        for (int i = 0; i < 5; i++) begin MOSI = 1'b1; cyc(); end
        SS_n = 1'b1; cyc();
        check("abort5_no_valid", {9'b0, rx_valid}, 10'd0);
        check("abort5_hold", rx_data, 10'h3FF);
        send_word(10'h155);
        check("post_abort_data", rx_data, 10'h155);
        check("post_abort_valid", {9'b0, rx_valid}, 10'd1);
        end_frame();

        // SS_n rises on the edge that would sample bit 0
        w = 10'h0F0;
        SS_n = 1'b0; cyc();
        for (int i = 9; i >= 1; i--) begin MOSI = w[i]; cyc(); end
        MOSI = w[0]; SS_n = 1'b1; cyc();
        check("abort_last_no_valid", {9'b0, rx_valid}, 10'd0);
        check("abort_last_hold", rx_data, 10'h155);

        // stale tx_valid held across the strobe; fresh data arrives at N+1
        tx_valid = 1'b1; tx_data = 8'hAA;
        send_word(10'h3C0);
        check("stale_strobe_data", rx_data, 10'h3C0);
        check("stale_miso_n", {9'b0, MISO}, 10'd0);
        cyc();
        tx_data = 8'h5B;
        check("stale_miso_n1", {9'b0, MISO}, 10'd0);
        cyc();
        capture8(b);
        check("stale_fresh_byte", {2'b0, b}, 10'h05B);
        tx_valid = 1'b0;
        end_frame();

        // reset in the middle of a read-data shift
        send_word(10'h2A5);
        end_frame();
        send_word(10'h300);
        tx_valid = 1'b1; tx_data = 8'hC3;
        cyc(); cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        check("midrst_rx_valid", {9'b0, rx_valid}, 10'd0);
        check("midrst_rx_data", rx_data, 10'h000);
        check("midrst_miso", {9'b0, MISO}, 10'd0);
        rst = 1'b0;
        end_frame();
        send_word(10'h3AA);
        miso_quiet(12, seen);
        check("midrst_rdd_cleared", {9'b0, seen}, 10'd0);
        tx_valid = 1'b0;
        end_frame();

        // randomized frames against the model
        rand_tx = 1'b1;
        for (int f = 0; f < 80; f++) begin
            w  = 10'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
            SS_n = 1'b0; MOSI = 1'($urandom);
            cyc();
            for (int i = 0; i < nb; i++) begin
                MOSI = w[9-i];
                cyc();
            end
            if (nb < 10) begin
                MOSI = w[9-nb];
                SS_n = 1'b1;
                cyc();
            end else begin
                extra = int'($urandom_range(0, 14));
                for (int i = 0; i < extra; i++) begin
                    MOSI = 1'($urandom);
                    rst  = ($urandom_range(0, 49) == 0);
                    cyc();
                    rst  = 1'b0;
                end
                SS_n = 1'b1;
                cyc();
            end
            if ($urandom_range(0, 1) == 1) cyc();
        end
        rand_tx = 1'b0; tx_valid = 1'b0; SS_n = 1'b1;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
